// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: shift-add multiply and restoring divide, 33-cycle latency.
// Define MULT_DIV_FAST_MULT_EN to commit MULT/MULTU in a single cycle instead of iterating.
module mult_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_MUL    = 2'd1;
  localparam logic [1:0] ST_DIV    = 2'd2;
  localparam logic [1:0] ST_FINISH = 2'd3;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  logic [1:0]  state_r;
  logic [4:0]  cnt_r;
  logic [31:0] a_raw_r;
  logic [31:0] opnd_r;     // multiplicand magnitude for MUL, divisor magnitude for DIV
  logic [63:0] acc_r;      // {partial product, remaining multiplier bits}
  logic [31:0] rem_r;
  logic [31:0] quo_r;      // dividend bits shift out the top as quotient bits shift in
  logic        is_div_r;
  logic        neg_q_r;
  logic        neg_r_r;
  logic        div0_r;

  logic        is_signed_s;
  logic        a_neg_s;
  logic        b_neg_s;
  logic [31:0] a_mag_s;
  logic [31:0] b_mag_s;
  logic [32:0] mul_sum_s;
  logic [63:0] mul_next_s;
  logic [32:0] div_part_s;
  logic [33:0] div_diff_s;
  logic [31:0] rem_next_s;
  logic [31:0] quo_next_s;
  logic [63:0] prod_fix_s;
  logic [31:0] quo_fix_s;
  logic [31:0] rem_fix_s;

  assign is_signed_s = ~op[0];
  assign a_neg_s     = is_signed_s & a[31];
  assign b_neg_s     = is_signed_s & b[31];
  assign a_mag_s     = a_neg_s ? (32'd0 - a) : a;
  assign b_mag_s     = b_neg_s ? (32'd0 - b) : b;

  assign mul_sum_s  = {1'b0, acc_r[63:32]} + (acc_r[0] ? {1'b0, opnd_r} : 33'd0);
  assign mul_next_s = {mul_sum_s, acc_r[31:1]};
  assign div_part_s = {rem_r, quo_r[31]};
  assign div_diff_s = {1'b0, div_part_s} - {2'b00, opnd_r};

`ifdef MULT_DIV_FAST_MULT_EN
  logic signed [63:0] fast_a_s;
  logic signed [63:0] fast_b_s;
  logic        [63:0] fast_prod_s;

  assign fast_a_s    = $signed({{32{a_neg_s}}, a});
  assign fast_b_s    = $signed({{32{b_neg_s}}, b});
  assign fast_prod_s = fast_a_s * fast_b_s;
`endif

  // Restoring-divide step: keep the trial difference only when it is non-negative.
  always_comb begin
    rem_next_s = div_part_s[31:0];
    quo_next_s = {quo_r[30:0], 1'b0};
    if (div_diff_s[33] == 1'b0) begin
      rem_next_s = div_diff_s[31:0];
      quo_next_s = {quo_r[30:0], 1'b1};
    end else begin
      rem_next_s = div_part_s[31:0];
      quo_next_s = {quo_r[30:0], 1'b0};
    end
  end

  // Two's-complement sign fixup of the magnitude results.
  always_comb begin
    prod_fix_s = acc_r;
    quo_fix_s  = quo_r;
    rem_fix_s  = rem_r;
    if (neg_q_r) begin
      prod_fix_s = 64'd0 - acc_r;
      quo_fix_s  = 32'd0 - quo_r;
    end else begin
      prod_fix_s = acc_r;
      quo_fix_s  = quo_r;
    end
    if (neg_r_r) begin
      rem_fix_s = 32'd0 - rem_r;
    end else begin
      rem_fix_s = rem_r;
    end
  end

  // Control FSM, operand latch, iteration datapath and HI/LO commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      cnt_r    <= 5'd0;
      a_raw_r  <= 32'd0;
      opnd_r   <= 32'd0;
      acc_r    <= 64'd0;
      rem_r    <= 32'd0;
      quo_r    <= 32'd0;
      is_div_r <= 1'b0;
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
      div0_r   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= 32'd0;
      lo       <= 32'd0;
    end else begin
      done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start && (op[2] == 1'b0)) begin
            a_raw_r  <= a;
            opnd_r   <= op[1] ? b_mag_s : a_mag_s;
            acc_r    <= {32'd0, b_mag_s};
            rem_r    <= 32'd0;
            quo_r    <= a_mag_s;
            is_div_r <= op[1];
            neg_q_r  <= a_neg_s ^ b_neg_s;
            neg_r_r  <= a_neg_s;
            div0_r   <= (b == 32'd0);
            cnt_r    <= 5'd0;
          end
          if (start) begin
            case (op)
              OP_MTHI: begin
                hi   <= a;
                done <= 1'b1;
              end
              OP_MTLO: begin
                lo   <= a;
                done <= 1'b1;
              end
              OP_MULT, OP_MULTU: begin
`ifdef MULT_DIV_FAST_MULT_EN
                hi   <= fast_prod_s[63:32];
                lo   <= fast_prod_s[31:0];
                done <= 1'b1;
`else
                state_r <= ST_MUL;
                busy    <= 1'b1;
`endif
              end
              OP_DIV, OP_DIVU: begin
                state_r <= ST_DIV;
                busy    <= 1'b1;
              end
              default: begin
                state_r <= ST_IDLE;
              end
            endcase
          end
        end
        ST_MUL: begin
          acc_r <= mul_next_s;
          cnt_r <= cnt_r + 5'd1;
          if (cnt_r == 5'd31) begin
            state_r <= ST_FINISH;
          end
        end
        ST_DIV: begin
          rem_r <= rem_next_s;
          quo_r <= quo_next_s;
          cnt_r <= cnt_r + 5'd1;
          if (cnt_r == 5'd31) begin
            state_r <= ST_FINISH;
          end
        end
        ST_FINISH: begin
          if (is_div_r) begin
            if (div0_r) begin
              hi <= a_raw_r;
              lo <= 32'hFFFF_FFFF;
            end else begin
              hi <= rem_fix_s;
              lo <= quo_fix_s;
            end
          end else begin
            hi <= prod_fix_s[63:32];
            lo <= prod_fix_s[31:0];
          end
          busy    <= 1'b0;
          done    <= 1'b1;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: driver pushes expected HI/LO/latency, monitor checks on done.
// Honours MULT_DIV_FAST_MULT_EN to expect single-cycle multiplies.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  always #5 clk = ~clk;

  mult_div_unit dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

`ifdef MULT_DIV_FAST_MULT_EN
  localparam int MUL_LAT = 0;
`else
  localparam int MUL_LAT = 33;
`endif

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  exp_t        sb_q[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] m_hi  = 32'd0;
  logic [31:0] m_lo  = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Architectural reference: plain 64-bit arithmetic, MIPS truncating division.
  function automatic exp_t ref_model(input logic [2:0] f_op, input logic [31:0] fa,
                                     input logic [31:0] fb, input logic [31:0] cur_hi,
                                     input logic [31:0] cur_lo);
    exp_t        e;
    longint      sa;
    longint      sb;
    logic [63:0] p;
    e.hi = cur_hi;
    e.lo = cur_lo;
    e.lat = 0;
    sa = longint'($signed(fa));
    sb = longint'($signed(fb));
    case (f_op)
      3'd0: begin
        p = sa * sb;
        e.hi = p[63:32]; e.lo = p[31:0]; e.lat = MUL_LAT;
      end
      3'd1: begin
        p = {32'd0, fa} * {32'd0, fb};
        e.hi = p[63:32]; e.lo = p[31:0]; e.lat = MUL_LAT;
      end
      3'd2, 3'd3: begin
        e.lat = 33;
        if (fb == 32'd0) begin
          e.hi = fa; e.lo = 32'hFFFF_FFFF;
        end else if (f_op == 3'd2) begin
          p = sa / sb; e.lo = p[31:0];
          p = sa % sb; e.hi = p[31:0];
        end else begin
          e.lo = fa / fb; e.hi = fa % fb;
        end
      end
      3'd4: e.hi = fa;
      3'd5: e.lo = fa;
      default: e.lat = 0;
    endcase
    return e;
  endfunction

  // Monitor: count busy cycles and check each done pulse against the scoreboard.
  int   busy_cnt = 0;
  exp_t mon_e;
  always @(negedge clk) begin
    if (busy) begin
      busy_cnt++;
    end else if (done) begin
      if (sb_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_done: hi=%h lo=%h with empty scoreboard", hi, lo);
      end else begin
        mon_e = sb_q.pop_front();
        check("hi", hi, mon_e.hi);
        check("lo", lo, mon_e.lo);
        check("busy_cycles", 32'(busy_cnt), 32'(mon_e.lat));
      end
      busy_cnt = 0;
    end else begin
      busy_cnt = 0;
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("busy_drop", 32'(busy), 32'd0);
  endtask

  task automatic expect_op(input logic [2:0] f_op, input logic [31:0] fa, input logic [31:0] fb);
    exp_t e;
    if (f_op <= 3'd5) begin
      e = ref_model(f_op, fa, fb, m_hi, m_lo);
      sb_q.push_back(e);
      m_hi = e.hi;
      m_lo = e.lo;
    end
  endtask

  task automatic issue(input logic [2:0] f_op, input logic [31:0] fa, input logic [31:0] fb);
    expect_op(f_op, fa, fb);
    start = 1'b1; op = f_op; a = fa; b = fb;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom;
    wait_idle();
    if (f_op >= 3'd4) @(negedge clk);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'(int'($urandom_range(0, 20)));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);

    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(3'd0, 32'hFFFF_FFFD, 32'd7);
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    issue(3'd3, 32'd7, 32'd0);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(3'd2, 32'hFFFF_FFF9, 32'd0);
    issue(3'd4, 32'hCAFE_0001, 32'd0);
    issue(3'd5, 32'h0BAD_F00D, 32'd0);

    // DIVU with an MTHI attempted while busy: it must be ignored.
    expect_op(3'd3, 32'd100, 32'd7);
    start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; op = 3'd4; a = 32'hDEAD_BEEF; b = 32'd0;
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Same divide, aborted by reset mid-flight.
    expect_op(3'd3, 32'd100, 32'd7);
    start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    void'(sb_q.pop_back());
    m_hi = 32'd0;
    m_lo = 32'd0;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    repeat (40) @(negedge clk);
    issue(3'd5, 32'h0000_1234, 32'd0);

    for (int i = 0; i < 60; i++) begin
      issue(3'($urandom_range(0, 7)), pick(), pick());
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
